// File: rtl/tx_stuff_nrzi_encoder_if.sv
// Timer-to-encoder handshake plus line and status outputs of the Tx bit-stuffing NRZI stage.
interface tx_stuff_nrzi_encoder_if;
  logic       sending;
  logic       load_enable;
  logic       shift_enable;
  logic [7:0] tx_byte;
  logic       eop_req;
  logic       stop_clock;
  logic       stop_clock_shift_enable;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_active;
  logic       eop_done;

  modport master (
    output sending, load_enable, shift_enable, tx_byte, eop_req,
    input  stop_clock, stop_clock_shift_enable, dplus_out, dminus_out, tx_active, eop_done
  );

  modport slave (
    input  sending, load_enable, shift_enable, tx_byte, eop_req,
    output stop_clock, stop_clock_shift_enable, dplus_out, dminus_out, tx_active, eop_done
  );
endinterface

// File: rtl/tx_stuff_nrzi_encoder.sv
// Serialises bytes LSB-first, inserts a stuffed 0 after STUFF_LEN ones, NRZI-encodes onto D+/D-,
// and appends SE0/J end-of-packet. Pauses the upstream timer while a stuff bit is on the line.
module tx_stuff_nrzi_encoder #(
  parameter int STUFF_LEN    = 6,
  parameter int BIT_CLKS     = 8,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  tx_stuff_nrzi_encoder_if.slave bus
);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int SW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int EW = $clog2(EOP_SE0_BITS + 1);

  localparam logic [OW-1:0] ONES_MAX     = OW'(STUFF_LEN);
  localparam logic [SW-1:0] STUFF_TOGGLE = SW'(BIT_CLKS - 2);
  localparam logic [SW-1:0] STUFF_LAST   = SW'(BIT_CLKS - 1);
  localparam logic [EW-1:0] SE0_LAST     = EW'(EOP_SE0_BITS);

  typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [OW-1:0]   ones_q, ones_d, ones_inc;
  logic [SW-1:0]   stuff_q, stuff_d;
  logic [EW-1:0]   se0_q, se0_d;
  logic            dp_q, dp_d, dm_q, dm_d;
  logic            stop_q, stop_d;
  logic            scse_q, scse_d;
  logic            done_q, done_d;

  assign ones_inc = ones_q + OW'(1);

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned
  // and no latch is inferred; the pulse outputs default to 0, everything else holds.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    stuff_d   = stuff_q;
    se0_d     = se0_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    stop_d    = stop_q;
    scse_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        dp_d   = 1'b1;
        dm_d   = 1'b0;
        ones_d = '0;
        stop_d = 1'b0;
        if (bus.load_enable && bus.sending) begin
          sr_d      = bus.tx_byte;
          bit_cnt_d = 4'd8;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (bus.load_enable) begin
          sr_d      = bus.tx_byte;
          bit_cnt_d = 4'd8;
        end else if (bus.shift_enable) begin
          if (bit_cnt_q != 4'd0) begin
            sr_d      = {1'b0, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q - 4'd1;
            if (!sr_q[0]) begin
              dp_d   = ~dp_q;
              dm_d   = ~dm_q;
              ones_d = '0;
            end else begin
              ones_d = ones_inc;
              if (ones_inc == ONES_MAX) begin
                state_d = STUFF;
                stuff_d = '0;
                stop_d  = 1'b1;
              end
            end
          end else if (bus.eop_req) begin
            dp_d    = 1'b0;
            dm_d    = 1'b0;
            se0_d   = EW'(1);
            state_d = EOP_SE0;
          end else begin
            // Underrun: keep the line alive with a 0 bit.
            dp_d   = ~dp_q;
            dm_d   = ~dm_q;
            ones_d = '0;
          end
        end
      end

      STUFF: begin
        if (bus.load_enable) begin
          sr_d      = bus.tx_byte;
          bit_cnt_d = 4'd8;
        end
        stuff_d = stuff_q + SW'(1);
        // Stuffed 0 and the timer's release pulse appear together in the last stop_clock cycle.
        if (stuff_q == STUFF_TOGGLE) begin
          scse_d = 1'b1;
          dp_d   = ~dp_q;
          dm_d   = ~dm_q;
          ones_d = '0;
        end
        if (stuff_q == STUFF_LAST) begin
          stop_d  = 1'b0;
          stuff_d = '0;
          state_d = DATA;
        end
      end

      EOP_SE0: begin
        if (bus.shift_enable) begin
          if (se0_q == SE0_LAST) begin
            dp_d    = 1'b1;
            dm_d    = 1'b0;
            se0_d   = '0;
            state_d = EOP_J;
          end else begin
            se0_d = se0_q + EW'(1);
          end
        end
      end

      EOP_J: begin
        if (bus.shift_enable) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Losing the transmission window aborts silently from anywhere.
    if (state_q != IDLE && !bus.sending) begin
      state_d   = IDLE;
      sr_d      = '0;
      bit_cnt_d = '0;
      ones_d    = '0;
      stuff_d   = '0;
      se0_d     = '0;
      dp_d      = 1'b1;
      dm_d      = 1'b0;
      stop_d    = 1'b0;
      scse_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
      stuff_q   <= '0;
      se0_q     <= '0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      stop_q    <= 1'b0;
      scse_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      stuff_q   <= stuff_d;
      se0_q     <= se0_d;
      dp_q      <= dp_d;
      dm_q      <= dm_d;
      stop_q    <= stop_d;
      scse_q    <= scse_d;
      done_q    <= done_d;
    end
  end

  assign bus.dplus_out               = dp_q;
  assign bus.dminus_out              = dm_q;
  assign bus.stop_clock              = stop_q;
  assign bus.stop_clock_shift_enable = scse_q;
  assign bus.eop_done                = done_q;
  assign bus.tx_active               = (state_q != IDLE);
endmodule
